// File: rtl/jtcop_prot_arb.sv
// Shared 2kB RAM arbiter between main 68000 and HuC6280 protection MCU, with main->MCU IRQ1 latch.
// Latency: request seen at edge n, RAM address at n+1, read data at n+2, main_ok / mcu_done at n+3.
// Backpressure: main side gets a level main_ok held until main_cs drops; MCU is stalled via mcu_waitn.
module jtcop_prot_arb #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_cs,
  input  logic          main_wrn,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_dout,
  output logic [DW-1:0] main_din,
  output logic          main_ok,
  input  logic          mcu_cs,
  input  logic          mcu_wrn,
  input  logic [AW-1:0] mcu_addr,
  input  logic [DW-1:0] mcu_dout,
  output logic [DW-1:0] mcu_din,
  output logic          mcu_waitn,
  output logic          mcu_irqn,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;

  logic main_req, mcu_req;
  logic start, pick_main;
  logic gnt_main;   // side owning the access in flight
  logic acc_wr;     // access in flight is a write
  logic last_main;  // side served most recently (0 = MCU)
  logic main_hold;  // blocks a new main access until main_cs has dropped
  logic mcu_done;   // one-cycle completion pulse for the MCU

  assign main_req  = main_cs & ~main_ok & ~main_hold;
  assign mcu_req   = mcu_cs & ~mcu_done;
  assign mcu_waitn = ~mcu_cs | mcu_done;

  // Next-state and grant decision; ties go to the side not served last
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pick_main = 1'b0;
    case (state)
      IDLE: begin
        if (main_req && mcu_req) begin
          start     = 1'b1;
          pick_main = ~last_main;
        end else if (main_req) begin
          start     = 1'b1;
          pick_main = 1'b1;
        end else if (mcu_req) begin
          start     = 1'b1;
          pick_main = 1'b0;
        end
        if (start) state_nxt = ADDR;
      end
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // RAM port registers, completion flags, read data capture and IRQ latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_we    <= 1'b0;
      main_din  <= {DW{1'b1}};
      mcu_din   <= {DW{1'b1}};
      main_ok   <= 1'b0;
      main_hold <= 1'b0;
      mcu_done  <= 1'b0;
      mcu_irqn  <= 1'b1;
      last_main <= 1'b0;
      gnt_main  <= 1'b0;
      acc_wr    <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      mcu_done <= 1'b0;
      // Once main_cs is seen low the main side may issue its next access
      if (!main_cs) begin
        main_ok   <= 1'b0;
        main_hold <= 1'b0;
      end
      if (start) begin
        gnt_main <= pick_main;
        ram_addr <= pick_main ? main_addr : mcu_addr;
        ram_data <= pick_main ? main_dout : mcu_dout;
        ram_we   <= pick_main ? ~main_wrn : ~mcu_wrn;
        acc_wr   <= pick_main ? ~main_wrn : ~mcu_wrn;
      end
      if (state == DATA) begin
        last_main <= gnt_main;
        if (gnt_main) begin
          if (!acc_wr) main_din <= ram_q;
          main_ok   <= 1'b1;
          main_hold <= 1'b1;
          // Main writing the last byte raises IRQ1 to the MCU
          if (acc_wr && ram_addr == {AW{1'b1}}) mcu_irqn <= 1'b0;
        end else begin
          if (!acc_wr) mcu_din <= ram_q;
          mcu_done <= 1'b1;
          // MCU reading the last byte acknowledges IRQ1
          if (!acc_wr && ram_addr == {AW{1'b1}}) mcu_irqn <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcop_prot_arb.sv
// Bench for jtcop_prot_arb: directed scenarios then randomized accesses against a transaction-level model.
// Latency: checks outputs 1 time unit after each rising clock edge.
// Backpressure: the bench drops main_cs on main_ok and mcu_cs on mcu_waitn rising, like the real CPUs.
module tb_jtcop_prot_arb;

  logic        clk;
  logic        rst_n;
  logic        main_cs, main_wrn, main_ok;
  logic [10:0] main_addr;
  logic [7:0]  main_dout, main_din;
  logic        mcu_cs, mcu_wrn, mcu_waitn, mcu_irqn;
  logic [10:0] mcu_addr;
  logic [7:0]  mcu_dout, mcu_din;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data, ram_q;
  logic        ram_we;

  logic [7:0] mem     [0:2047];
  logic [7:0] ref_mem [0:2047];

  int n_assert = 0;
  int n_fail   = 0;

  jtcop_prot_arb #(.AW(11), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr), .main_dout(main_dout),
    .main_din(main_din), .main_ok(main_ok),
    .mcu_cs(mcu_cs), .mcu_wrn(mcu_wrn), .mcu_addr(mcu_addr), .mcu_dout(mcu_dout),
    .mcu_din(mcu_din), .mcu_waitn(mcu_waitn), .mcu_irqn(mcu_irqn),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        use_main, use_mcu, first_main;
    logic        m_last_main, m_irqn;
    logic [7:0]  exp_main_din, exp_mcu_din, obs_main_din, obs_mcu_din;
    logic [10:0] ma, ca;
    logic [7:0]  md, cd;
    logic        mw, cw;
    int          exp_main_t, exp_mcu_t, got_main, got_mcu, mode;

    rst_n = 1'b0;
    main_cs = 1'b0; main_wrn = 1'b1; main_addr = '0; main_dout = '0;
    mcu_cs = 1'b0;  mcu_wrn = 1'b1;  mcu_addr = '0;  mcu_dout = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
    step(); step();

    // Reset state
    check("rst_main_ok", main_ok, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_main_din", main_din, 8'hFF);
    check("rst_mcu_din", mcu_din, 8'hFF);
    check("rst_irqn", mcu_irqn, 1);
    check("rst_waitn", mcu_waitn, 1);
    rst_n = 1'b1;
    step();

    // 1: main-only read
    mem[11'h010] = 8'h5A;
    main_wrn = 1'b1; main_addr = 11'h010; main_cs = 1'b1;
    step();
    check("t1_ram_addr", ram_addr, 11'h010);
    check("t1_ok_n", main_ok, 0);
    step();
    check("t1_ok_n1", main_ok, 0);
    step();
    check("t1_ok", main_ok, 1);
    check("t1_din", main_din, 8'h5A);
    step(); step();
    check("t1_ok_held", main_ok, 1);
    main_cs = 1'b0;
    step();
    check("t1_ok_fall", main_ok, 0);

    // 2: MCU-only write
    mcu_wrn = 1'b0; mcu_addr = 11'h123; mcu_dout = 8'hA5; mcu_cs = 1'b1;
    #1;
    check("t2_waitn_req", mcu_waitn, 0);
    step();
    check("t2_we", ram_we, 1);
    check("t2_addr", ram_addr, 11'h123);
    check("t2_data", ram_data, 8'hA5);
    check("t2_waitn_n", mcu_waitn, 0);
    step();
    check("t2_we_off", ram_we, 0);
    check("t2_waitn_n1", mcu_waitn, 0);
    step();
    check("t2_waitn_done", mcu_waitn, 1);
    mcu_cs = 1'b0;
    step();
    check("t2_ram_content", mem[11'h123], 8'hA5);

    // 3: simultaneous requests after reset: main first, then MCU
    rst_n = 1'b0; step(); rst_n = 1'b1;
    main_wrn = 1'b1; main_addr = 11'h010; main_cs = 1'b1;
    mcu_wrn = 1'b1; mcu_addr = 11'h123; mcu_cs = 1'b1;
    step();
    check("t3_first_main", ram_addr, 11'h010);
    step(); step();
    check("t3_main_ok", main_ok, 1);
    check("t3_mcu_wait", mcu_waitn, 0);
    main_cs = 1'b0;
    step();
    check("t3_second_mcu", ram_addr, 11'h123);
    step(); step();
    check("t3_mcu_done", mcu_waitn, 1);
    check("t3_mcu_din", mcu_din, 8'hA5);
    check("t3_main_din", main_din, 8'h5A);
    mcu_cs = 1'b0;
    step();
    // main-only access makes main the last served
    main_addr = 11'h123; main_cs = 1'b1;
    step(); step(); step();
    check("t3_solo_din", main_din, 8'hA5);
    main_cs = 1'b0;
    step();
    // tie again: MCU now wins
    main_addr = 11'h010; main_cs = 1'b1; mcu_cs = 1'b1;
    step();
    check("t3_tie_mcu", ram_addr, 11'h123);
    step(); step();
    check("t3_tie_mcu_done", mcu_waitn, 1);
    check("t3_tie_main_wait", main_ok, 0);
    mcu_cs = 1'b0;
    step(); step(); step();
    check("t3_tie_main_ok", main_ok, 1);
    check("t3_tie_main_din", main_din, 8'h5A);
    main_cs = 1'b0;
    step();

    // 4: IRQ set by main write to 7FF, cleared by MCU read of 7FF
    main_wrn = 1'b0; main_addr = 11'h7FF; main_dout = 8'h01; main_cs = 1'b1;
    step(); step();
    check("t4_irq_pending", mcu_irqn, 1);
    step();
    check("t4_irq_set", mcu_irqn, 0);
    main_cs = 1'b0;
    step();
    mcu_wrn = 1'b1; mcu_addr = 11'h7FF; mcu_cs = 1'b1;
    step(); step();
    check("t4_irq_still", mcu_irqn, 0);
    step();
    check("t4_mcu_din", mcu_din, 8'h01);
    check("t4_irq_clr", mcu_irqn, 1);
    mcu_cs = 1'b0;
    step();

    // 5: reset in the middle of an access
    main_wrn = 1'b0; main_addr = 11'h7FF; main_dout = 8'h02; main_cs = 1'b1;
    step(); step(); step();
    check("t5_irq_pre", mcu_irqn, 0);
    main_cs = 1'b0;
    step();
    mcu_wrn = 1'b0; mcu_addr = 11'h055; mcu_dout = 8'h77; mcu_cs = 1'b1;
    step();
    check("t5_we_pre", ram_we, 1);
    rst_n = 1'b0;
    step();
    check("t5_we", ram_we, 0);
    check("t5_ok", main_ok, 0);
    check("t5_irq", mcu_irqn, 1);
    check("t5_addr", ram_addr, 0);
    check("t5_waitn_cs1", mcu_waitn, 0);
    rst_n = 1'b1; mcu_cs = 1'b0;
    #1;
    check("t5_waitn_cs0", mcu_waitn, 1);
    step();

    // 6: main_cs held after ok: no second main access, MCU still served
    main_wrn = 1'b1; main_addr = 11'h010; main_cs = 1'b1;
    step(); step(); step();
    check("t6_ok", main_ok, 1);
    mcu_wrn = 1'b1; mcu_addr = 11'h123; mcu_cs = 1'b1;
    step();
    check("t6_mcu_grant", ram_addr, 11'h123);
    step(); step();
    check("t6_mcu_done", mcu_waitn, 1);
    check("t6_mcu_din", mcu_din, 8'hA5);
    mcu_cs = 1'b0;
    step(); step(); step();
    check("t6_no_regrant", ram_addr, 11'h123);
    check("t6_ok_held", main_ok, 1);
    main_cs = 1'b0;
    step();
    check("t6_ok_fall", main_ok, 0);

    // Randomized accesses against a transaction-level model
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];
    m_last_main = 1'b0; m_irqn = 1'b1;
    exp_main_din = 8'hFF; exp_mcu_din = 8'hFF;
    for (int it = 0; it < 60; it++) begin
      mode = int'($urandom_range(0, 2));
      use_main = (mode != 1);
      use_mcu  = (mode != 0);
      ma = 11'h7F0 + 11'($urandom_range(0, 15));
      ca = 11'h7F0 + 11'($urandom_range(0, 15));
      md = 8'($urandom); cd = 8'($urandom);
      mw = 1'($urandom_range(0, 1)); cw = 1'($urandom_range(0, 1));
      first_main = use_main && (!use_mcu || !m_last_main);
      exp_main_t = -1; exp_mcu_t = -1;
      if (use_main) exp_main_t = (first_main || !use_mcu) ? 2 : 5;
      if (use_mcu)  exp_mcu_t  = (use_main && first_main) ? 5 : 2;
      // model: apply accesses in service order
      for (int k = 0; k < 2; k++) begin
        logic side_main;
        logic active;
        side_main = (k == 0) ? first_main : !first_main;
        active = side_main ? use_main : use_mcu;
        if (active) begin
          if (side_main) begin
            if (mw) exp_main_din = ref_mem[ma];
            else begin
              ref_mem[ma] = md;
              if (ma == 11'h7FF) m_irqn = 1'b0;
            end
          end else begin
            if (cw) begin
              exp_mcu_din = ref_mem[ca];
              if (ca == 11'h7FF) m_irqn = 1'b1;
            end else ref_mem[ca] = cd;
          end
          m_last_main = side_main;
        end
      end
      // drive and observe
      main_wrn = mw; main_addr = ma; main_dout = md; main_cs = use_main;
      mcu_wrn = cw; mcu_addr = ca; mcu_dout = cd; mcu_cs = use_mcu;
      got_main = -1; got_mcu = -1;
      obs_main_din = 8'h00; obs_mcu_din = 8'h00;
      for (int c = 0; c < 12; c++) begin
        step();
        if (main_cs && main_ok && got_main < 0) begin
          got_main = c; obs_main_din = main_din; main_cs = 1'b0;
        end
        if (mcu_cs && mcu_waitn && got_mcu < 0) begin
          got_mcu = c; obs_mcu_din = mcu_din; mcu_cs = 1'b0;
        end
      end
      main_cs = 1'b0; mcu_cs = 1'b0;
      if (use_main) begin
        check("rnd_main_lat", got_main, exp_main_t);
        check("rnd_main_din", obs_main_din, exp_main_din);
      end
      if (use_mcu) begin
        check("rnd_mcu_lat", got_mcu, exp_mcu_t);
        check("rnd_mcu_din", obs_mcu_din, exp_mcu_din);
      end
      check("rnd_irqn", mcu_irqn, m_irqn);
      check("rnd_ok_idle", main_ok, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
